fetch_prefetch_queue: RTL and testbench

//  Parametrised fetch stage: owns the fetch PC, issues requests to a 1-cycle-latency instruction memory,

---
 rtl/fetch_prefetch_queue.sv | 176 +++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: owns the fetch PC, issues requests to a 1-cycle-latency instruction
// memory, buffers returned words in a small prefetch queue and drives the IF/ID register.
// An epoch bit tags every request so responses issued before a redirect are discarded.
module fetch_prefetch_queue #(
    parameter int unsigned     XLEN     = 16,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_INC   = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_o,
    output logic [XLEN-1:0]          imem_addr_o,
    input  logic [XLEN-1:0]          imem_rdata_i,
    input  logic                     imem_rvalid_i,
    input  logic                     redirect_i,
    input  logic [XLEN-1:0]          redirect_pc_i,
    input  logic                     stall_d_i,
    input  logic                     flush_d_i,
    output logic [XLEN-1:0]          instr_d_o,
    output logic [XLEN-1:0]          pc_d_o,
    output logic [XLEN-1:0]          pc_plus_d_o,
    output logic                     valid_d_o,
    output logic [$clog2(DEPTH):0]   q_count_o
);

    localparam int unsigned     PtrW   = $clog2(DEPTH);
    localparam logic [XLEN-1:0] Inc    = XLEN'(PC_INC);
    localparam logic [PtrW:0]   DepthC = (PtrW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic [XLEN-1:0] q_instr_q [DEPTH];
    logic [XLEN-1:0] q_instr_d [DEPTH];
    logic [XLEN-1:0] q_pc_q    [DEPTH];
    logic [XLEN-1:0] q_pc_d    [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_epoch_q, inflight_epoch_d;
    logic            epoch_q, epoch_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus_q, pc_plus_d;
    logic            valid_q, valid_d;

    logic            rsp_ok;
    logic            normal;
    logic            pop;
    logic            bypass;
    logic            push;
    logic [PtrW:0]   occupancy;

    // Credit: queued words plus the outstanding request never exceed DEPTH, so a push
    // always finds room even when decode is stalled.
    assign occupancy  = count_q + {{PtrW{1'b0}}, inflight_q};
    assign imem_req_o = !rst && !redirect_i && (occupancy < DepthC);
    assign imem_addr_o = pc_f_q;

    assign rsp_ok = imem_rvalid_i && inflight_q && (inflight_epoch_q == epoch_q);
    assign normal = !redirect_i && !flush_d_i && !stall_d_i;
    assign pop    = normal && (count_q != '0);
    // Bypass only with an empty queue so FIFO order is preserved.
    assign bypass = normal && (count_q == '0) && rsp_ok;
    assign push   = rsp_ok && !redirect_i && !bypass;

    // Next state for fetch PC, prefetch queue and the outstanding-request tag.
    always_comb begin
        pc_f_d           = pc_f_q;
        q_instr_d        = q_instr_q;
        q_pc_d           = q_pc_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        count_d          = count_q;
        epoch_d          = epoch_q;
        inflight_d       = imem_req_o;
        inflight_pc_d    = pc_f_q;
        inflight_epoch_d = epoch_q;
        if (redirect_i) begin
            pc_f_d   = redirect_pc_i;
            epoch_d  = ~epoch_q;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (imem_req_o) begin
                pc_f_d = pc_f_q + Inc;
            end
            if (push) begin
                q_instr_d[wr_ptr_q] = imem_rdata_i;
                q_pc_d[wr_ptr_q]    = inflight_pc_q;
                wr_ptr_d            = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
        end
    end

    // Next state for the IF/ID register: redirect > flush > stall > pop/bypass/bubble.
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pc_plus_d = pc_plus_q;
        valid_d   = valid_q;
        if (redirect_i || flush_d_i) begin
            instr_d   = '0;
            pc_d      = '0;
            pc_plus_d = '0;
            valid_d   = 1'b0;
        end else if (stall_d_i) begin
            valid_d = valid_q;
        end else if (pop) begin
            instr_d   = q_instr_q[rd_ptr_q];
            pc_d      = q_pc_q[rd_ptr_q];
            pc_plus_d = q_pc_q[rd_ptr_q] + Inc;
            valid_d   = 1'b1;
        end else if (bypass) begin
            instr_d   = imem_rdata_i;
            pc_d      = inflight_pc_q;
            pc_plus_d = inflight_pc_q + Inc;
            valid_d   = 1'b1;
        end else begin
            instr_d   = '0;
            pc_d      = '0;
            pc_plus_d = '0;
            valid_d   = 1'b0;
        end
    end

    // State registers; reset drops any outstanding request and empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f_q           <= RESET_PC;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_instr_q[i] <= '0;
                q_pc_q[i]    <= '0;
            end
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            inflight_q       <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_epoch_q <= 1'b0;
            epoch_q          <= 1'b0;
            instr_q          <= '0;
            pc_q             <= '0;
            pc_plus_q        <= '0;
            valid_q          <= 1'b0;
        end else begin
            pc_f_q           <= pc_f_d;
            q_instr_q        <= q_instr_d;
            q_pc_q           <= q_pc_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            inflight_q       <= inflight_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_epoch_q <= inflight_epoch_d;
            epoch_q          <= epoch_d;
            instr_q          <= instr_d;
            pc_q             <= pc_d;
            pc_plus_q        <= pc_plus_d;
            valid_q          <= valid_d;
        end
    end

    assign instr_d_o   = instr_q;
    assign pc_d_o      = pc_q;
    assign pc_plus_d_o = pc_plus_q;
    assign valid_d_o   = valid_q;
    assign q_count_o   = count_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: a 1-cycle memory model returns mem[k] = k + 0x100.
// Stimulus pushes the expected PC stream into a scoreboard; a negedge monitor pops and
// compares whenever IF/ID loads a new valid instruction, and checks held contents on stalls.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic [15:0] imem_rdata_i;
    logic        imem_rvalid_i;
    logic        redirect_i = 1'b0;
    logic [15:0] redirect_pc_i = '0;
    logic        stall_d_i = 1'b0;
    logic        flush_d_i = 1'b0;
    logic [15:0] instr_d_o;
    logic [15:0] pc_d_o;
    logic [15:0] pc_plus_d_o;
    logic        valid_d_o;
    logic [2:0]  q_count_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q [$];

    fetch_prefetch_queue #(
        .XLEN     (16),
        .DEPTH    (4),
        .PC_INC   (1),
        .RESET_PC (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .imem_rvalid_i (imem_rvalid_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_d_i     (stall_d_i),
        .flush_d_i     (flush_d_i),
        .instr_d_o     (instr_d_o),
        .pc_d_o        (pc_d_o),
        .pc_plus_d_o   (pc_plus_d_o),
        .valid_d_o     (valid_d_o),
        .q_count_o     (q_count_o)
    );

    always #5 clk = ~clk;

    // Memory model: answers every request exactly one cycle later; it is not reset,
    // so a request made just before a reset still produces a (stale) response.
    logic        mem_pend = 1'b0;
    logic [15:0] mem_addr = '0;
    always @(posedge clk) begin
        mem_pend <= imem_req_o;
        mem_addr <= imem_addr_o;
    end
    assign imem_rvalid_i = mem_pend;
    assign imem_rdata_i  = mem_addr + 16'h0100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: an edge taken under stall (and no redirect/flush) must hold IF/ID.
    logic        edge_hold = 1'b0;
    logic        snap_valid = 1'b0;
    logic [15:0] snap_pc = '0;
    logic [15:0] snap_instr = '0;
    logic [15:0] snap_plus = '0;
    always @(posedge clk) begin
        edge_hold <= stall_d_i && !redirect_i && !flush_d_i && !rst;
    end
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst) begin
            if (edge_hold) begin
                check("hold_valid", 32'(valid_d_o), 32'(snap_valid));
                check("hold_pc", 32'(pc_d_o), 32'(snap_pc));
                check("hold_instr", 32'(instr_d_o), 32'(snap_instr));
                check("hold_pc_plus", 32'(pc_plus_d_o), 32'(snap_plus));
            end else if (valid_d_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got pc %h instr %h expected no instruction",
                             pc_d_o, instr_d_o);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", 32'(pc_d_o), 32'(e));
                    check("sb_instr", 32'(instr_d_o), 32'(16'(e + 16'h0100)));
                    check("sb_pc_plus", 32'(pc_plus_d_o), 32'(16'(e + 16'd1)));
                end
            end
        end
        snap_valid <= valid_d_o;
        snap_pc    <= pc_d_o;
        snap_instr <= instr_d_o;
        snap_plus  <= pc_plus_d_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(16'(start + 16'(i)));
        end
    endtask

    task automatic check_bubble(input string name);
        check({name, "_valid"}, 32'(valid_d_o), 32'd0);
        check({name, "_pc"}, 32'(pc_d_o), 32'd0);
        check({name, "_instr"}, 32'(instr_d_o), 32'd0);
    endtask

    initial begin
        logic [2:0] stall_cnt [6];
        logic       stall_req [6];
        stall_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
        stall_req = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        check_bubble("rst");
        check("rst_pc_plus", 32'(pc_plus_d_o), 32'd0);
        check("rst_count", 32'(q_count_o), 32'd0);
        check("rst_req", 32'(imem_req_o), 32'd0);

        // 1: stream from reset, one instruction per cycle from the 2nd edge
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_range(16'h0000, 17);
        #1;
        check("t1_req", 32'(imem_req_o), 32'd1);
        check("t1_addr", 32'(imem_addr_o), 32'd0);
        tick();
        check("t1_first_edge_valid", 32'(valid_d_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t1_valid", 32'(valid_d_o), 32'd1);
        end

        // 2: six-cycle stall fills the queue, then drains in order
        stall_d_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t2_stall_valid", 32'(valid_d_o), 32'd1);
            check("t2_stall_count", 32'(q_count_o), 32'(stall_cnt[k]));
            check("t2_stall_req", 32'(imem_req_o), 32'(stall_req[k]));
        end
        stall_d_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t2_drain_valid", 32'(valid_d_o), 32'd1);
        end
        check("t2_count", 32'(q_count_o), 32'd2);

        // 4: one-cycle flush with a non-empty queue loses nothing
        flush_d_i = 1'b1;
        tick();
        check_bubble("t4_flush");
        check("t4_count", 32'(q_count_o), 32'd3);
        flush_d_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_resume_valid", 32'(valid_d_o), 32'd1);
        end

        // 3: redirect with a response in flight
        redirect_i    = 1'b1;
        redirect_pc_i = 16'h0040;
        #1;
        check("t3_req_blocked", 32'(imem_req_o), 32'd0);
        tick();
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check_bubble("t3_redirect");
        check("t3_count", 32'(q_count_o), 32'd0);
        redirect_i = 1'b0;
        push_range(16'h0040, 3);
        #1;
        check("t3_req", 32'(imem_req_o), 32'd1);
        check("t3_addr", 32'(imem_addr_o), 32'h40);
        tick();
        check("t3_second_bubble", 32'(valid_d_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_valid", 32'(valid_d_o), 32'd1);
        end

        // 5: redirect + flush + stall together; fetch wraps past 0xFFFF
        redirect_i    = 1'b1;
        flush_d_i     = 1'b1;
        stall_d_i     = 1'b1;
        redirect_pc_i = 16'hFFFF;
        tick();
        check("t5_drained", 32'(exp_q.size()), 32'd0);
        check_bubble("t5_redirect");
        check("t5_count", 32'(q_count_o), 32'd0);
        redirect_i = 1'b0;
        flush_d_i  = 1'b0;
        stall_d_i  = 1'b0;
        #1;
        check("t5_addr_ffff", 32'(imem_addr_o), 32'hFFFF);
        tick();
        check("t5_bubble2", 32'(valid_d_o), 32'd0);
        check("t5_addr_wrap", 32'(imem_addr_o), 32'h0000);
        push_range(16'hFFFF, 4);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_valid", 32'(valid_d_o), 32'd1);
        end

        // 6: asynchronous reset mid-stream; stale response must be ignored
        @(negedge clk);
        #1;
        check("t6_drained", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        #1;
        check_bubble("t6_rst");
        check("t6_rst_pc_plus", 32'(pc_plus_d_o), 32'd0);
        check("t6_rst_count", 32'(q_count_o), 32'd0);
        check("t6_rst_req", 32'(imem_req_o), 32'd0);
        rst = 1'b0;
        push_range(16'h0000, 4);
        #1;
        check("t6_req", 32'(imem_req_o), 32'd1);
        check("t6_addr", 32'(imem_addr_o), 32'd0);
        tick();
        check("t6_stale_ignored", 32'(valid_d_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_valid", 32'(valid_d_o), 32'd1);
        end
        @(negedge clk);
        #1;
        check("t6_drained_end", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
